core_dispatch_n: RTL
====================

CORE_DISPATCH_N -- requirements
Module: core_dispatch_n

Interface
REQ-001 The block SHALL have parameter WIDTH, default 2, meaning issue and accept width in instructions per cycle (1..4).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning instruction queue entries (power of two, at least WIDTH).
REQ-003 The block SHALL have parameter WB_PORTS, default 2, meaning number of writeback ports that clear scoreboard bits.
REQ-004 Register numbers SHALL be 4 bits (16 architectural registers); the unit class SHALL be 2 bits: 0 ALU, 1 MUL, 2 LDST, 3 BRANCH.
REQ-005 The block SHALL be clocked by port clk (input, 1 bit), the single clock.
REQ-006 The block SHALL have port rst (input, 1 bit): asynchronous, active-high reset.
REQ-007 The block SHALL have port in_count (input, clog2(WIDTH+1) bits): number of instructions offered this cycle, occupying slots 0..in_count-1; slot 0 is oldest.
REQ-008 The block SHALL have port in_ready (output, 1 bit): queue free entries >= WIDTH.
REQ-009 The block SHALL have ports in_ra, in_rb, in_rd (input, WIDTH*4 bits each) and in_uses_ra, in_uses_rb, in_writes_rd (input, WIDTH bits each) carrying per-slot operand fields.
REQ-010 The block SHALL have ports in_class (input, WIDTH*2 bits) and in_tag (input, WIDTH*16 bits): unit class and opaque payload (PC/immediate index) per slot.
REQ-011 The block SHALL have ports flush (input, 1 bit), which discards queued instructions, and single_busy (input, 1 bit), which indicates the shared MUL/LDST/BRANCH unit cannot accept.
REQ-012 The block SHALL have ports wb_valid (input, WB_PORTS bits) and wb_rd (input, WB_PORTS*4 bits): register writebacks.
REQ-013 The block SHALL have ports issue_valid (output, WIDTH bits), issue_ra, issue_rb, issue_rd (output, WIDTH*4 bits), issue_class (output, WIDTH*2 bits) and issue_tag (output, WIDTH*16 bits), all registered; lane 0 is oldest.
REQ-014 The block SHALL have port busy_mask (output, 16 bits): current scoreboard.

Function
REQ-015 Accept: when in_ready=1 and in_count>0, slots 0..in_count-1 SHALL be written to the queue tail in order; in_count>0 with in_ready=0 SHALL be ignored (source holds).
REQ-016 Candidates: each cycle the oldest min(occupancy, WIDTH) entries SHALL be the candidates, the head being candidate 0.
REQ-017 Candidate k SHALL issue only if candidates 0..k-1 issue (strictly in order, no skipping).
REQ-018 Candidate k SHALL block on RAW when a used source register has its scoreboard bit set or equals the rd of an older writing candidate issuing this cycle.
REQ-019 Candidate k SHALL block on WAW when it writes rd and busy_mask[rd]=1 or an older issuing candidate writes the same rd.
REQ-020 Structural: at most one non-ALU candidate SHALL issue per cycle, none while single_busy=1; ALU issue is limited only by WIDTH.
REQ-021 Register write: issued candidates SHALL appear on issue lanes 0..n-1 the next cycle with issue_valid set; unused lanes SHALL drive issue_valid=0 with other fields don't-care.
REQ-022 Dequeue: the head SHALL advance by n in the same edge; occupancy_next = occupancy - n + accepted.
REQ-023 Latency: an instruction accepted at edge t SHALL be a candidate in cycle t+1 and at minimum appear on issue at edge t+2.
REQ-024 Same-cycle accept and issue SHALL both apply; in_ready SHALL derive from registered occupancy only (no combinational path from issue).
REQ-025 Pointers SHALL wrap modulo DEPTH; occupancy SHALL be a clog2(DEPTH+1)-bit counter and never exceed DEPTH.
REQ-026 Scoreboard: a writing issue SHALL set its rd bit at that edge; a wb_valid port SHALL clear its wb_rd bit at that edge; set SHALL win over clear for the same register in the same cycle; writebacks SHALL NOT bypass same-cycle hazard checks.
REQ-027 Flush: occupancy and pointers SHALL reset to empty, no candidate SHALL issue that cycle, issue_valid SHALL be 0 next cycle, incoming slots SHALL be dropped, and the scoreboard SHALL be retained (in-flight writes still complete).

Reset
REQ-028 Upon rst=1, asynchronously: queue empty, pointers 0, busy_mask=0, issue_valid=0, in_ready=1; payload storage unreset.
REQ-029 Reset asserted mid-operation SHALL abandon all queued and issuing instructions; the first accept SHALL be possible at the first edge after rst falls.

Verification
REQ-030 The bench SHALL cover this scenario: WIDTH=2, two independent ALU ops (rd r1, r2) -> both on lanes 0/1 two edges later, busy_mask=0x0006.
REQ-031 The bench SHALL cover this scenario: slot0 writes r3, slot1 reads r3 -> lane 0 only; slot1 held until wb_rd=3 is seen, then it issues one cycle after the clear.
REQ-032 The bench SHALL cover this scenario: two LDST ops back-to-back -> one per cycle; with single_busy=1 held 3 cycles, neither issues until it drops.
REQ-033 The bench SHALL cover this scenario: DEPTH=4, 6 instructions offered while head blocked on r5 -> in_ready=0 after 4 accepted, source holds, no entry lost or duplicated after the r5 writeback.
REQ-034 The bench SHALL cover this scenario: flush with 3 entries queued and r7 busy -> issue_valid=0 next cycle, queue empty, busy_mask bit 7 still set until wb_rd=7.
REQ-035 The bench SHALL cover this scenario: issue setting r4 and wb clearing r4 in the same cycle -> busy_mask[4]=1 afterwards.

Source files
------------

// File: rtl/core_dispatch_n.sv
// core_dispatch_n: in-order N-wide dispatch queue with a register scoreboard.
// It issues the oldest instructions and checks RAW/WAW hazards and the single shared non-ALU unit.
module core_dispatch_n #(
  parameter int WIDTH = 2,
  parameter int DEPTH = 4,
  parameter int WB_PORTS = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [$clog2(WIDTH+1)-1:0] in_count,
  output logic                       in_ready,
  input  logic [WIDTH*4-1:0]         in_ra,
  input  logic [WIDTH*4-1:0]         in_rb,
  input  logic [WIDTH*4-1:0]         in_rd,
  input  logic [WIDTH-1:0]           in_uses_ra,
  input  logic [WIDTH-1:0]           in_uses_rb,
  input  logic [WIDTH-1:0]           in_writes_rd,
  input  logic [WIDTH*2-1:0]         in_class,
  input  logic [WIDTH*16-1:0]        in_tag,
  input  logic                       flush,
  input  logic                       single_busy,
  input  logic [WB_PORTS-1:0]        wb_valid,
  input  logic [WB_PORTS*4-1:0]      wb_rd,
  output logic [WIDTH-1:0]           issue_valid,
  output logic [WIDTH*4-1:0]         issue_ra,
  output logic [WIDTH*4-1:0]         issue_rb,
  output logic [WIDTH*4-1:0]         issue_rd,
  output logic [WIDTH*2-1:0]         issue_class,
  output logic [WIDTH*16-1:0]        issue_tag,
  output logic [15:0]                busy_mask
);
  localparam int OW = $clog2(DEPTH+1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  // Entry layout: ra[32:29] rb[28:25] rd[24:21] uses_ra[20] uses_rb[19] writes_rd[18] class[17:16] tag[15:0]
  logic [32:0] mem_q [DEPTH];
  logic [32:0] e;
  logic [PW-1:0] head_q, head_d, tail_q, tail_d;
  logic [OW-1:0] occ_q, occ_d, acc, n;
  logic [15:0] busy_q, busy_d, pend;
  logic ok, nonalu;
  logic [WIDTH-1:0] valid_q, valid_d;
  logic [WIDTH*4-1:0] ra_q, ra_d, rb_q, rb_d, rd_q, rd_d;
  logic [WIDTH*2-1:0] cls_q, cls_d;
  logic [WIDTH*16-1:0] tag_q, tag_d;
  assign in_ready = occ_q <= OW'(DEPTH - WIDTH);
  assign acc = (in_ready && !flush) ? OW'(in_count) : '0;
  assign busy_mask = busy_q;
  assign issue_valid = valid_q;
  assign issue_ra = ra_q;
  assign issue_rb = rb_q;
  assign issue_rd = rd_q;
  assign issue_class = cls_q;
  assign issue_tag = tag_q;
  // A busy shared unit is modelled as the non-ALU slot already being taken.
  always_comb begin
    ok = !flush;
    nonalu = single_busy;
    pend = '0;
    n = '0;
    e = '0;
    valid_d = '0;
    ra_d = '0;
    rb_d = '0;
    rd_d = '0;
    cls_d = '0;
    tag_d = '0;
    for (int k = 0; k < WIDTH; k++) begin
      e = mem_q[PW'((int'(head_q) + k) % DEPTH)];
      ra_d[k*4+:4] = e[32:29];
      rb_d[k*4+:4] = e[28:25];
      rd_d[k*4+:4] = e[24:21];
      cls_d[k*2+:2] = e[17:16];
      tag_d[k*16+:16] = e[15:0];
      ok = ok && (OW'(k) < occ_q)
        && !(e[20] && (busy_q[e[32:29]] || pend[e[32:29]]))
        && !(e[19] && (busy_q[e[28:25]] || pend[e[28:25]]))
        && !(e[18] && (busy_q[e[24:21]] || pend[e[24:21]]))
        && !((e[17:16] != 2'd0) && nonalu);
      valid_d[k] = ok;
      pend = pend | ((ok && e[18]) ? (16'd1 << e[24:21]) : 16'd0);
      nonalu = nonalu | (ok && (e[17:16] != 2'd0));
      n = n + (ok ? OW'(1) : OW'(0));
    end
  end
  // Issue-time sets are applied after writeback clears so a same-register set wins.
  always_comb begin
    busy_d = busy_q;
    for (int w = 0; w < WB_PORTS; w++)
      busy_d = busy_d & ~(wb_valid[w] ? (16'd1 << wb_rd[w*4+:4]) : 16'd0);
    busy_d = busy_d | pend;
    occ_d = flush ? '0 : occ_q - n + acc;
    head_d = flush ? '0 : PW'((int'(head_q) + int'(n)) % DEPTH);
    tail_d = flush ? '0 : PW'((int'(tail_q) + int'(acc)) % DEPTH);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      head_q <= '0;
      tail_q <= '0;
      busy_q <= '0;
      valid_q <= '0;
      ra_q <= '0;
      rb_q <= '0;
      rd_q <= '0;
      cls_q <= '0;
      tag_q <= '0;
    end else begin
      occ_q <= occ_d;
      head_q <= head_d;
      tail_q <= tail_d;
      busy_q <= busy_d;
      valid_q <= valid_d;
      ra_q <= ra_d;
      rb_q <= rb_d;
      rd_q <= rd_d;
      cls_q <= cls_d;
      tag_q <= tag_d;
    end
  end
  always_ff @(posedge clk) begin
    for (int j = 0; j < WIDTH; j++)
      if (OW'(j) < acc)
        mem_q[PW'((int'(tail_q) + j) % DEPTH)] <= {in_ra[j*4+:4], in_rb[j*4+:4], in_rd[j*4+:4],
          in_uses_ra[j], in_uses_rb[j], in_writes_rd[j], in_class[j*2+:2], in_tag[j*16+:16]};
  end
endmodule
